// File: rtl/uart_rom_loader_pkg.sv
// Shared encodings for the UART ROM loader: loader FSM states, receiver states,
// and the header length check.
package uart_rom_loader_pkg;

    localparam logic [2:0] LD_LEN_HI  = 3'd0;
    localparam logic [2:0] LD_LEN_LO  = 3'd1;
    localparam logic [2:0] LD_WORD_HI = 3'd2;
    localparam logic [2:0] LD_WORD_LO = 3'd3;
    localparam logic [2:0] LD_WRITE   = 3'd4;
    localparam logic [2:0] LD_DONE    = 3'd5;
    localparam logic [2:0] LD_ERROR   = 3'd6;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // A full ROM (N == 2^aw) is legal; only strictly larger images are rejected.
    function automatic logic len_oversize(input logic [15:0] n, input int aw);
        return (aw < 16) && ({16'b0, n} > (32'd1 << aw));
    endfunction

endpackage

// File: rtl/uart_rom_loader_rx.sv
// 8N1 UART byte receiver with 2-flop input synchroniser, mid-bit sampling
// and start-bit glitch rejection.
module uart_rx
    import uart_rom_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s1, rx_s2;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s2) state <= RX_START;
                end
                RX_START: begin
                    // Re-check mid start bit; a high line here was only a glitch.
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rom_loader.sv
// Boot loader: receives a length-prefixed word image over UART, writes it into
// the instruction ROM and holds the CPU in reset until the image is complete.
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [15:0]           rom_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    logic            byte_valid, frame_err;
    logic [7:0]      rx_byte;
    logic [2:0]      state;
    logic [7:0]      len_hi, hi_byte;
    logic [ADDR_WIDTH:0] len, count, count_nxt;
    logic [15:0]     n;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    assign n         = {len_hi, rx_byte};
    assign count_nxt = count + (ADDR_WIDTH + 1)'(1);

    assign rom_we    = (state == LD_WRITE);
    assign done      = (state == LD_DONE);
    assign error     = (state == LD_ERROR);
    assign cpu_reset = (state != LD_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LD_LEN_HI;
            len_hi   <= '0;
            hi_byte  <= '0;
            len      <= '0;
            count    <= '0;
            rom_addr <= '0;
            rom_data <= '0;
        end else if (frame_err && state != LD_DONE && state != LD_ERROR) begin
            state <= LD_ERROR;
        end else begin
            case (state)
                LD_LEN_HI: if (byte_valid) begin
                    len_hi <= rx_byte;
                    state  <= LD_LEN_LO;
                end
                LD_LEN_LO: if (byte_valid) begin
                    len <= (ADDR_WIDTH + 1)'(n);
                    if (len_oversize(n, ADDR_WIDTH)) state <= LD_ERROR;
                    else if (n == 16'd0)             state <= LD_DONE;
                    else                             state <= LD_WORD_HI;
                end
                LD_WORD_HI: if (byte_valid) begin
                    hi_byte <= rx_byte;
                    state   <= LD_WORD_LO;
                end
                LD_WORD_LO: if (byte_valid) begin
                    rom_data <= {hi_byte, rx_byte};
                    state    <= LD_WRITE;
                end
                LD_WRITE: begin
                    // Address wraps after a full-size image, but no further write follows.
                    rom_addr <= rom_addr + 1'b1;
                    count    <= count_nxt;
                    state    <= (count_nxt == len) ? LD_DONE : LD_WORD_HI;
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Scoreboarded bench for uart_rom_loader: expected ROM writes are queued by the
// stimulus, and a negedge monitor pops and compares every rom_we pulse.
module tb_uart_rom_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          uart_rx = 1'b1;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          cpu_reset, done, error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_we_cyc = -1;
    int done_cyc = -1;
    int wr_cnt = 0;
    logic done_prev = 1'b0;
    logic [AW+15:0] exp_q[$];

    uart_rom_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            wr_cnt++;
            last_we_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", rom_addr, rom_data);
            end else begin
                logic [AW+15:0] e;
                e = exp_q.pop_front();
                if ({rom_addr, rom_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             rom_addr, rom_data, e[AW+15:16], e[15:0]);
                end
            end
        end
        if (done === 1'b1 && !done_prev) done_cyc = cyc;
        done_prev = done;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        done_cyc = -1;
        last_we_cyc = -1;
        wr_cnt = 0;
    endtask

    task automatic wait_settle(input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && error !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done/error expected one within 200 cycles", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string name);
        @(negedge clk);
        chk({name, "_rom_we"},    32'(rom_we),    32'd0);
        chk({name, "_rom_addr"},  32'(rom_addr),  32'd0);
        chk({name, "_rom_data"},  32'(rom_data),  32'd0);
        chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({name, "_done"},      32'(done),      32'd0);
        chk({name, "_error"},     32'(error),     32'd0);
    endtask

    task automatic chk_done(input string name, input int writes);
        chk({name, "_done"},      32'(done),      32'd1);
        chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({name, "_error"},     32'(error),     32'd0);
        chk({name, "_writes"},    32'(wr_cnt),    32'(writes));
        chk({name, "_pending"},   32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_error(input string name, input int writes);
        chk({name, "_error"},     32'(error),     32'd1);
        chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({name, "_done"},      32'(done),      32'd0);
        chk({name, "_writes"},    32'(wr_cnt),    32'(writes));
        chk({name, "_pending"},   32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        apply_reset();
        chk_reset_vals("reset");

        // Two-word image
        exp_q.push_back({4'd0, 16'h1234});
        exp_q.push_back({4'd1, 16'hABCD});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        wait_settle("two");
        chk_done("two", 2);
        chk("two_done_latency", 32'(done_cyc), 32'(last_we_cyc + 1));

        // Empty image
        apply_reset();
        send_byte(8'h00); send_byte(8'h00);
        wait_settle("empty");
        chk_done("empty", 0);

        // Full 16-word image, last write at address 15
        apply_reset();
        send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({4'(i), 8'h10 + 8'(i), 8'hF0 - 8'(i)});
            send_byte(8'h10 + 8'(i));
            send_byte(8'hF0 - 8'(i));
        end
        wait_settle("full");
        chk_done("full", 16);
        chk("full_done_latency", 32'(done_cyc), 32'(last_we_cyc + 1));

        // Oversize image: 17 words with 4 address bits
        apply_reset();
        send_byte(8'h00); send_byte(8'h11);
        wait_settle("over");
        chk_error("over", 0);

        // Framing error on a low byte; later bytes must be ignored
        apply_reset();
        exp_q.push_back({4'd0, 16'h1234});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78, 1'b0);
        wait_settle("ferr");
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h9A); send_byte(8'hBC);
        repeat (10) @(negedge clk);
        chk_error("ferr", 1);

        // One-cycle glitch while idle, then a good load
        apply_reset();
        @(posedge clk); #1;
        uart_rx = 1'b0;
        @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_done", 32'(done), 32'd0);
        chk("glitch_error", 32'(error), 32'd0);
        chk("glitch_cpu_reset", 32'(cpu_reset), 32'd1);
        exp_q.push_back({4'd0, 16'hBEEF});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF);
        wait_settle("glitch");
        chk_done("glitch", 1);

        // Reset mid-load aborts, next header restarts at address 0
        apply_reset();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        apply_reset();
        chk_reset_vals("midrst");
        exp_q.push_back({4'd0, 16'h55AA});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'hAA);
        wait_settle("midrst");
        chk_done("midrst", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
